// File: rtl/layer_mixer.sv
// layer_mixer: final stage of the sprite-layer pipeline.
//   - Picks the lowest-index layer that is requesting with a non-transparent
//     colour. Falls back to bg_rgb when no layer qualifies. Forces black
//     outside the active area.
//   - Registers RGB together with hsync/vsync/de so that all of them leave
//     the block with the same 1-cycle latency.
//   - Generates the frame-synchronous animation select action_s.
//   - Counts frame starts and reports whether any active pixel of the
//     previous frame had two or more valid layer requests.
// Ports:
//   pixel_clk, rst            clock and synchronous active-high reset
//   x_pos, y_pos              timing-generator position (observation only)
//   hsync_in, vsync_in, de_in timing aligned with the current pixel
//   rq_flags, layer_rgb       per-layer request flag and {r,g,b} colour
//   bg_rgb                    background colour
//   freeze                    holds the animation counter and action_s
//   r, g, b, hsync, vsync, de registered VGA outputs
//   action_s                  animation frame select fed to every layer
//   frame_cnt                 wrapping count of frame starts
//   overlap_frame             overlap seen during the previous frame
module layer_mixer #(
  parameter int          NUM_LAYERS  = 6,
  parameter int          ANIM_FRAMES = 8,
  parameter bit          SYNC_POL    = 1'b0,
  parameter logic [23:0] TRANSPARENT = 24'hFFFFCC
) (
  input  logic                       pixel_clk,
  input  logic                       rst,
  input  logic [9:0]                 x_pos,
  input  logic [8:0]                 y_pos,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       de_in,
  input  logic [NUM_LAYERS-1:0]      rq_flags,
  input  logic [24*NUM_LAYERS-1:0]   layer_rgb,
  input  logic [23:0]                bg_rgb,
  input  logic                       freeze,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       de,
  output logic                       action_s,
  output logic [15:0]                frame_cnt,
  output logic                       overlap_frame
);

  localparam logic       SYNC_IDLE = ~SYNC_POL;
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

  logic [NUM_LAYERS-1:0] valid_s;
  logic [7:0]            nvalid_s;
  logic [23:0]           sel_rgb_s;
  logic                  overlap_s;
  logic                  frame_start_s;
  logic                  vsync_prev_r;
  logic                  overlap_acc_r;
  logic [7:0]            anim_cnt_r;
  logic                  unused_pos_s;

  // Position is carried on the port list for observation only.
  assign unused_pos_s = ^{x_pos, y_pos};

  // Qualify each request against the colour key and count the survivors.
  always_comb begin
    valid_s  = {NUM_LAYERS{1'b0}};
    nvalid_s = 8'd0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      valid_s[i] = rq_flags[i] && (layer_rgb[24*i +: 24] != TRANSPARENT);
      nvalid_s   = nvalid_s + 8'(valid_s[i]);
    end
  end

  // Priority pick: walk from the lowest priority upwards so index 0 ends up on top.
  always_comb begin
    sel_rgb_s = bg_rgb;
    if (de_in) begin
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
        sel_rgb_s = valid_s[i] ? layer_rgb[24*i +: 24] : sel_rgb_s;
      end
    end else begin
      sel_rgb_s = 24'h000000;
    end
  end

  assign overlap_s     = de_in && (nvalid_s >= 8'd2);
  assign frame_start_s = (vsync_in == SYNC_POL) && (vsync_prev_r == SYNC_IDLE);

  // Output register: RGB and timing share one stage so they stay aligned.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      {r, g, b} <= 24'h000000;
      hsync     <= SYNC_IDLE;
      vsync     <= SYNC_IDLE;
      de        <= 1'b0;
    end else begin
      {r, g, b} <= sel_rgb_s;
      hsync     <= hsync_in;
      vsync     <= vsync_in;
      de        <= de_in;
    end
  end

  // Frame-start edge detect, frame counter and overlap bookkeeping.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vsync_prev_r  <= SYNC_IDLE;
      frame_cnt     <= 16'd0;
      overlap_frame <= 1'b0;
      overlap_acc_r <= 1'b0;
    end else begin
      vsync_prev_r <= vsync_in;
      if (frame_start_s) begin
        frame_cnt     <= frame_cnt + 16'd1;
        overlap_frame <= overlap_acc_r;
        // An overlap on the very first cycle of a frame belongs to that new frame.
        overlap_acc_r <= overlap_s;
      end else if (overlap_s) begin
        overlap_acc_r <= 1'b1;
      end else begin
        overlap_acc_r <= overlap_acc_r;
      end
    end
  end

  // Animation counter: only moves on frame starts, so action_s never tears mid-frame.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      anim_cnt_r <= 8'd0;
      action_s   <= 1'b0;
    end else if (frame_start_s && !freeze) begin
      if (anim_cnt_r >= ANIM_LAST) begin
        anim_cnt_r <= 8'd0;
        action_s   <= ~action_s;
      end else begin
        anim_cnt_r <= anim_cnt_r + 8'd1;
      end
    end else begin
      anim_cnt_r <= anim_cnt_r;
      action_s   <= action_s;
    end
  end

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Consumer end of the sprite-layer request interface.
- Each layer block presents a request flag plus a 24-bit RGB value for the current pixel.
- This block picks the winning layer by fixed priority, falls back to a background colour, blanks outside the active area, and registers the final RGB together with the delayed sync/DE for the VGA output pins.
- It also generates the frame-synchronous animation select `action_s`, which feeds every layer's ActionS input, and reports per-frame layer overlap.

Parameters:
- NUM_LAYERS, 6: number of layer request/RGB inputs; index 0 has the highest priority.
- ANIM_FRAMES, 8: number of frames between `action_s` toggles; legal range 1..255.
- SYNC_POL, 0: active level of `hsync_in`/`vsync_in` (0 = active-low). Outputs keep the same polarity.
- TRANSPARENT, 24'hFFFFCC: colour key. A requesting layer whose RGB equals this value is ignored.

Ports:
- pixel_clk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- x_pos  in  10  current pixel column from the timing generator.
- y_pos  in  9  current pixel row from the timing generator.
- hsync_in  in  1  horizontal sync aligned with x_pos/y_pos.
- vsync_in  in  1  vertical sync aligned with x_pos/y_pos.
- de_in  in  1  display enable (active area) aligned with x_pos/y_pos.
- rq_flags  in  NUM_LAYERS  per-layer request; bit i belongs to layer i.
- layer_rgb  in  24*NUM_LAYERS  layer i colour in bits [24i+23:24i], ordered {r,g,b}.
- bg_rgb  in  24  background colour.
- freeze  in  1  1 = hold `action_s` and the animation counter (pause/run control).
- r  out  8  registered red.
- g  out  8  registered green.
- b  out  8  registered blue.
- hsync  out  1  hsync_in delayed by 1 cycle.
- vsync  out  1  vsync_in delayed by 1 cycle.
- de  out  1  de_in delayed by 1 cycle.
- action_s  out  1  animation frame select driven to all layers.
- frame_cnt  out  16  count of frame starts, wrapping.
- overlap_frame  out  1  1 if two or more layers requested on one active pixel during the previous frame.

Behaviour:
- Reset values:
  - r, g, b, de: 0.
  - hsync, vsync: inactive level (~SYNC_POL).
  - action_s: 0. frame_cnt: 0. overlap_frame: 0.
  - Internal anim counter: 0. Overlap accumulator: 0. Previous-vsync register: inactive.
- Valid request for layer i: rq_flags[i]=1 AND layer_rgb[i] != TRANSPARENT.
- Selection (combinational from the current inputs):
  - The lowest-index valid layer wins.
  - If no layer is valid, bg_rgb is used.
  - If de_in=0, the selection is 24'h000000 regardless of requests.
- Latency: exactly 1 cycle. {r,g,b,hsync,vsync,de} at edge t+1 reflect the inputs sampled at edge t, so RGB and sync/DE stay aligned.
- x_pos/y_pos are not used for selection. They exist for bench observation only and must be kept in the port list.
- Frame start: the cycle where vsync_in transitions from the inactive level to the active level, detected against the registered previous value.
- On each frame start:
  - frame_cnt increments, wrapping 16'hFFFF -> 0.
  - overlap_frame is loaded from the accumulator.
  - The accumulator is cleared. If an overlap is also detected that same cycle, the accumulator is set to 1 instead, so the new frame's first event wins.
- Overlap accumulator: set when de_in=1 and the count of valid requests is >= 2. It is sticky until the next frame start.
- Animation:
  - When freeze=0, the anim counter increments on each frame start.
  - When the counter reaches ANIM_FRAMES-1 and a frame start occurs, the counter goes to 0 and action_s toggles.
  - `action_s` changes only on a frame-start cycle, which guarantees no mid-frame tearing.
  - When freeze=1, the counter and action_s hold, while frame_cnt still counts.
  - When freeze deasserts, counting resumes from the held value.
- A vsync_in that is held at the active level produces no further frame starts.
- Reset asserted mid-frame returns everything to reset values on the next edge. The first frame start after reset increments frame_cnt to 1.

Test Plan:
- Priority: de_in=1, rq_flags=6'b000110, layer1=24'h112233, layer2=24'h445566 -> next cycle {r,g,b}=24'h112233. Then rq_flags=0, bg_rgb=24'h0000FF -> {r,g,b}=24'h0000FF.
- Transparency: rq_flags=6'b000011, layer0=24'hFFFFCC, layer1=24'hABCDEF -> output 24'hABCDEF. With layer1 also 24'hFFFFCC -> output bg_rgb.
- Blanking/latency: drive a de_in/hsync_in pattern 1,1,0,0 with requests held -> de and hsync replicate the pattern 1 cycle later, and RGB=0 exactly on the cycles where de=0.
- Animation: ANIM_FRAMES=2, 5 frame starts with freeze=0 -> action_s toggles after the 2nd and 4th (final 0), frame_cnt=5. Repeat with freeze=1 over 3 frames -> action_s unchanged, frame_cnt advances by 3.
- Overlap: frame N contains one active pixel with rq_flags=6'b100001 (both non-transparent) -> overlap_frame=1 after start of N+1. A clean frame N+1 -> overlap_frame=0 after start of N+2.
- Reset mid-frame: assert rst for 1 cycle with frame_cnt=3 and action_s=1 -> all outputs at reset values on the next edge. The next frame start gives frame_cnt=1.
